sbox_init_engine: RTL and testbench
===================================

SBOX_INIT_ENGINE -- requirements
Module: sbox_init_engine

Interface
REQ-001 Parameter ADDR_W, default 8, memory address width.
REQ-002 Parameter DATA_W, default 8, memory data width.
REQ-003 Parameter DEPTH, default 256, number of words processed; the block SHALL require 1 <= DEPTH <= 2**ADDR_W (elaboration error otherwise).
REQ-004 Port clk  in  1  clock; reset reset_n, synchronous, active-low; clock clk.
REQ-005 Port reset_n  in  1  synchronous active-low reset.
REQ-006 Port start  in  1  request; sampled only in IDLE.
REQ-007 Port mode  in  2  operation select (rc4_pkg::init_mode_t): IDENT=0, REVERSE=1, FILL=2, CHECK=3.
REQ-008 Port fill_value  in  DATA_W  constant for FILL; sampled with start.
REQ-009 Port address  out  ADDR_W  memory address.
REQ-010 Port wr_data  out  DATA_W  memory write data.
REQ-011 Port wren  out  1  memory write enable.
REQ-012 Port rd_data  in  DATA_W  memory read data, valid exactly one cycle after address is presented.
REQ-013 Port busy  out  1  high while an operation is in progress.
REQ-014 Port done  out  1  single-cycle completion pulse.
REQ-015 Port err  out  1  CHECK found at least one mismatch; held until next accepted start.
REQ-016 Port err_addr  out  ADDR_W  address of first mismatch; held until next accepted start.
REQ-017 Port err_count  out  ADDR_W+1  number of mismatches; held until next accepted start.

Function
REQ-018 States SHALL be IDLE, WRITE, READ, DRAIN, DONE; outputs SHALL be registered.
REQ-019 IDLE: start=1 SHALL latch mode and fill_value, clear err/err_addr/err_count and the index counter, and enter WRITE (IDENT/REVERSE/FILL) or READ (CHECK).
REQ-020 The index counter SHALL be ADDR_W+1 bits wide so DEPTH=2**ADDR_W terminates without wrap-around.
REQ-021 WRITE: one word per cycle, wren=1, address=i for i=0..DEPTH-1; start accepted at cycle T gives writes in cycles T+1..T+DEPTH.
REQ-022 wr_data SHALL be i (IDENT), DEPTH-1-i (REVERSE), or fill_value (FILL), truncated to the low DATA_W bits.
REQ-023 After the write for i=DEPTH-1, the block SHALL enter DONE; done=1 in cycle T+DEPTH+1, wren=0.
REQ-024 READ: wren=0, address=i for i=0..DEPTH-1 in cycles T+1..T+DEPTH; then DRAIN for one cycle to capture the last read.
REQ-025 CHECK SHALL compare rd_data in cycle T+2+i against expected i[DATA_W-1:0]; on mismatch err_count increments, err sets, and err_addr captures i only on the first mismatch.
REQ-026 CHECK: done=1 in cycle T+DEPTH+2.
REQ-027 busy SHALL be 1 in WRITE, READ, DRAIN; 0 in IDLE and DONE.
REQ-028 DONE SHALL last exactly one cycle, then return to IDLE; start during busy or DONE SHALL be ignored (not queued).
REQ-029 mode or fill_value changes while busy SHALL have no effect.
REQ-030 When not in WRITE, wren SHALL be 0; address SHALL hold its last value in IDLE/DONE.

Reset
REQ-031 reset_n=0 at a clock edge SHALL force IDLE, address=0, wr_data=0, wren=0, busy=0, done=0, err=0, err_addr=0, err_count=0, counter=0.
REQ-032 Reset mid-operation SHALL abort immediately with no further writes and no done pulse.

Structure
REQ-033 rc4_pkg SHALL hold init_mode_t and the state enum; the block SHALL have no sub-modules except an optional compare/counter helper sbox_check_unit for REQ-025.

Verification
REQ-034 Defaults, IDENT: start at cycle T -> 256 writes addr=data=0..255 in T+1..T+256, wren never high after, done pulse at T+257, busy high 256 cycles.
REQ-035 REVERSE, DEPTH=16, ADDR_W=4: addr 0 data 15 ... addr 15 data 0; then FILL fill_value=0xA5 -> all 16 words 0xA5, done once.
REQ-036 CHECK against memory loaded by IDENT with words 3 and 200 corrupted -> err=1, err_addr=3, err_count=2, done at T+258; clean memory -> err=0, err_count=0.
REQ-037 start held high continuously -> one operation per IDLE visit, no start accepted while busy or in DONE; mode toggled mid-run does not alter data.
REQ-038 reset_n low at write i=100 -> wren=0 next cycle, no done; fresh start afterwards completes a full 256-write run.

Source files
------------

// File: rtl/rc4_pkg.sv
// Shared types for the S-box initialisation engine: operation modes and FSM states.
package rc4_pkg;

  typedef enum logic [1:0] {
    IDENT   = 2'd0,
    REVERSE = 2'd1,
    FILL    = 2'd2,
    CHECK   = 2'd3
  } init_mode_t;

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    READ,
    DRAIN,
    DONE
  } state_t;

endpackage

// File: rtl/sbox_check_unit.sv
// Compares read-back words against their index and accumulates mismatch
// status (first failing address, count) until cleared by a new operation.
module sbox_check_unit #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clear,
  input  logic              cmp_valid,
  input  logic [ADDR_W-1:0] cmp_idx,
  input  logic [DATA_W-1:0] rd_data,
  output logic              err,
  output logic [ADDR_W-1:0] err_addr,
  output logic [ADDR_W:0]   err_count
);

  logic              err_q, err_d;
  logic [ADDR_W-1:0] err_addr_q, err_addr_d;
  logic [ADDR_W:0]   err_count_q, err_count_d;
  logic [DATA_W-1:0] exp_word;

  always_comb begin
    exp_word    = DATA_W'(cmp_idx);
    err_d       = err_q;
    err_addr_d  = err_addr_q;
    err_count_d = err_count_q;
    if (clear) begin
      err_d       = 1'b0;
      err_addr_d  = '0;
      err_count_d = '0;
    end else if (cmp_valid && (rd_data != exp_word)) begin
      err_d       = 1'b1;
      err_count_d = err_count_q + 1'b1;
      if (!err_q) err_addr_d = cmp_idx;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      err_q       <= 1'b0;
      err_addr_q  <= '0;
      err_count_q <= '0;
    end else begin
      err_q       <= err_d;
      err_addr_q  <= err_addr_d;
      err_count_q <= err_count_d;
    end
  end

  assign err       = err_q;
  assign err_addr  = err_addr_q;
  assign err_count = err_count_q;

endmodule

// File: rtl/sbox_init_engine.sv
// Sequences DEPTH memory writes (identity, reverse or fill pattern) or a
// read-back identity check, one word per cycle with registered outputs.
module sbox_init_engine
  import rc4_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  init_mode_t        mode,
  input  logic [DATA_W-1:0] fill_value,
  output logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] wr_data,
  output logic              wren,
  input  logic [DATA_W-1:0] rd_data,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-1:0] err_addr,
  output logic [ADDR_W:0]   err_count
);

  if (DEPTH < 1 || DEPTH > (2 ** ADDR_W)) begin : g_bad_depth
    $error("sbox_init_engine: DEPTH must be in 1..2**ADDR_W");
  end

  localparam logic [ADDR_W:0] LAST = (ADDR_W + 1)'(DEPTH);

  state_t            state_q, state_d;
  init_mode_t        mode_q, mode_d;
  logic [DATA_W-1:0] fill_q, fill_d;
  logic [ADDR_W:0]   idx_q, idx_d;
  logic [ADDR_W-1:0] address_q, address_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic              wren_q, wren_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              cmp_valid_q, cmp_valid_d;
  logic [ADDR_W-1:0] cmp_idx_q, cmp_idx_d;
  logic              clear;

  function automatic logic [DATA_W-1:0] word_for(init_mode_t m, logic [ADDR_W:0] i,
                                                 logic [DATA_W-1:0] f);
    logic [31:0] rev;
    rev = 32'(DEPTH) - 32'd1 - 32'(i);
    case (m)
      IDENT:   return DATA_W'(i);
      REVERSE: return DATA_W'(rev);
      default: return f;
    endcase
  endfunction

  // The first word is issued on the accepting edge, so idx holds the next index.
  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    fill_d      = fill_q;
    idx_d       = idx_q;
    address_d   = address_q;
    wr_data_d   = wr_data_q;
    wren_d      = 1'b0;
    busy_d      = busy_q;
    done_d      = 1'b0;
    clear       = 1'b0;
    cmp_valid_d = (state_q == READ);
    cmp_idx_d   = address_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          clear     = 1'b1;
          mode_d    = mode;
          fill_d    = fill_value;
          idx_d     = (ADDR_W + 1)'(1);
          address_d = '0;
          busy_d    = 1'b1;
          if (mode == CHECK) begin
            state_d = READ;
          end else begin
            state_d   = WRITE;
            wren_d    = 1'b1;
            wr_data_d = word_for(mode, '0, fill_value);
          end
        end
      end
      WRITE: begin
        if (idx_q == LAST) begin
          state_d = DONE;
          done_d  = 1'b1;
          busy_d  = 1'b0;
        end else begin
          wren_d    = 1'b1;
          address_d = idx_q[ADDR_W-1:0];
          wr_data_d = word_for(mode_q, idx_q, fill_q);
          idx_d     = idx_q + 1'b1;
        end
      end
      READ: begin
        if (idx_q == LAST) begin
          state_d = DRAIN;
        end else begin
          address_d = idx_q[ADDR_W-1:0];
          idx_d     = idx_q + 1'b1;
        end
      end
      DRAIN: begin
        state_d = DONE;
        done_d  = 1'b1;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      mode_q      <= IDENT;
      fill_q      <= '0;
      idx_q       <= '0;
      address_q   <= '0;
      wr_data_q   <= '0;
      wren_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      cmp_valid_q <= 1'b0;
      cmp_idx_q   <= '0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      fill_q      <= fill_d;
      idx_q       <= idx_d;
      address_q   <= address_d;
      wr_data_q   <= wr_data_d;
      wren_q      <= wren_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      cmp_valid_q <= cmp_valid_d;
      cmp_idx_q   <= cmp_idx_d;
    end
  end

  sbox_check_unit #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_check (
    .clk      (clk),
    .reset_n  (reset_n),
    .clear    (clear),
    .cmp_valid(cmp_valid_q),
    .cmp_idx  (cmp_idx_q),
    .rd_data  (rd_data),
    .err      (err),
    .err_addr (err_addr),
    .err_count(err_count)
  );

  assign address = address_q;
  assign wr_data = wr_data_q;
  assign wren    = wren_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule

// File: tb/tb_sbox_init_engine.sv
// Bench for sbox_init_engine: default instance (256 words) plus a 16-word instance.
module tb_sbox_init_engine;
  import rc4_pkg::*;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       start = 1'b0;
  logic       sel = 1'b0;
  logic [1:0] mode_r = 2'd0;
  logic [7:0] fill = 8'd0;

  always #5 clk = ~clk;

  logic       b_start, s_start;
  assign b_start = start & ~sel;
  assign s_start = start & sel;

  logic [7:0] b_address, b_wr_data, b_rd_data, b_err_addr;
  logic       b_wren, b_busy, b_done, b_err;
  logic [8:0] b_err_count;
  logic [3:0] s_address, s_err_addr;
  logic [7:0] s_wr_data, s_rd_data;
  logic       s_wren, s_busy, s_done, s_err;
  logic [4:0] s_err_count;

  sbox_init_engine u_big (
    .clk(clk), .reset_n(reset_n), .start(b_start), .mode(init_mode_t'(mode_r)),
    .fill_value(fill), .address(b_address), .wr_data(b_wr_data), .wren(b_wren),
    .rd_data(b_rd_data), .busy(b_busy), .done(b_done), .err(b_err),
    .err_addr(b_err_addr), .err_count(b_err_count)
  );

  sbox_init_engine #(.ADDR_W(4), .DATA_W(8), .DEPTH(16)) u_small (
    .clk(clk), .reset_n(reset_n), .start(s_start), .mode(init_mode_t'(mode_r)),
    .fill_value(fill), .address(s_address), .wr_data(s_wr_data), .wren(s_wren),
    .rd_data(s_rd_data), .busy(s_busy), .done(s_done), .err(s_err),
    .err_addr(s_err_addr), .err_count(s_err_count)
  );

  // Memory models: one-cycle registered read; poke lets the bench corrupt words.
  logic [7:0] b_mem [256];
  logic [7:0] s_mem [16];
  logic       poke_en = 1'b0;
  logic [7:0] poke_addr = 8'd0, poke_data = 8'd0;

  always @(posedge clk) begin
    if (poke_en) b_mem[poke_addr] <= poke_data;
    else if (b_wren) b_mem[b_address] <= b_wr_data;
    b_rd_data <= b_mem[b_address];
  end

  always @(posedge clk) begin
    if (s_wren) s_mem[s_address] <= s_wr_data;
    s_rd_data <= s_mem[s_address];
  end

  logic [7:0] o_addr, o_wdata, o_err_addr;
  logic       o_wren, o_busy, o_done, o_err;
  logic [8:0] o_err_count;
  assign o_addr      = sel ? {4'd0, s_address} : b_address;
  assign o_wdata     = sel ? s_wr_data : b_wr_data;
  assign o_wren      = sel ? s_wren : b_wren;
  assign o_busy      = sel ? s_busy : b_busy;
  assign o_done      = sel ? s_done : b_done;
  assign o_err       = sel ? s_err : b_err;
  assign o_err_addr  = sel ? {4'd0, s_err_addr} : b_err_addr;
  assign o_err_count = sel ? {4'd0, s_err_count} : b_err_count;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int wr_cyc[$];
  int wr_addr[$];
  int wr_dat[$];
  int done_cyc[$];
  int busy_cnt = 0;

  always @(negedge clk) begin
    if (o_wren) begin
      wr_cyc.push_back(cyc);
      wr_addr.push_back(int'(o_addr));
      wr_dat.push_back(int'(o_wdata));
    end
    if (o_done) done_cyc.push_back(cyc);
    if (o_busy) busy_cnt++;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input int idx, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s[%0d] observed=%0h expected=%0h", tag, idx, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  function automatic logic [7:0] exp_word(int m, int i, int dep, logic [7:0] fv);
    case (m)
      0:       return 8'(i);
      1:       return 8'(dep - 1 - i);
      default: return fv;
    endcase
  endfunction

  task automatic check_idle_zero(input string tag);
    chk({tag, "_addr"}, 0, o_addr, 0);
    chk({tag, "_wdata"}, 0, o_wdata, 0);
    chk({tag, "_wren"}, 0, o_wren, 0);
    chk({tag, "_busy"}, 0, o_busy, 0);
    chk({tag, "_done"}, 0, o_done, 0);
    chk({tag, "_err"}, 0, o_err, 0);
    chk({tag, "_err_addr"}, 0, o_err_addr, 0);
    chk({tag, "_err_count"}, 0, o_err_count, 0);
  endtask

  // Launch one operation; optionally scramble mode/fill/start while it runs.
  task automatic launch(input int m, input logic [7:0] fv, input bit scramble, input int dep,
                        output int t0, output int wb, output int db, output int bb);
    int n;
    step();
    wb = wr_cyc.size();
    db = done_cyc.size();
    bb = busy_cnt;
    start = 1'b1;
    mode_r = 2'(m);
    fill = fv;
    t0 = cyc;
    step();
    start = 1'b0;
    n = 0;
    while (done_cyc.size() == db && n < dep + 20) begin
      if (scramble) begin
        mode_r = 2'($urandom);
        fill = 8'($urandom);
        start = 1'($urandom);
      end
      step();
      n++;
    end
    start = 1'b0;
    repeat (3) step();
  endtask

  task automatic run_write(input string tag, input int m, input logic [7:0] fv,
                           input bit scramble);
    int dep, t0, wb, db, bb, nw;
    dep = sel ? 16 : 256;
    launch(m, fv, scramble, dep, t0, wb, db, bb);
    nw = wr_cyc.size() - wb;
    chk({tag, "_nwrites"}, 0, nw, dep);
    for (int i = 0; i < dep && i < nw; i++) begin
      chk({tag, "_waddr"}, i, wr_addr[wb+i], i);
      chk({tag, "_wdata"}, i, wr_dat[wb+i], exp_word(m, i, dep, fv));
      chk({tag, "_wcycle"}, i, wr_cyc[wb+i], t0 + 1 + i);
    end
    chk({tag, "_ndone"}, 0, done_cyc.size() - db, 1);
    if (done_cyc.size() > db) chk({tag, "_done_cycle"}, 0, done_cyc[db], t0 + dep + 1);
    chk({tag, "_busy_cycles"}, 0, busy_cnt - bb, dep);
    chk({tag, "_err"}, 0, o_err, 0);
    chk({tag, "_err_count"}, 0, o_err_count, 0);
  endtask

  task automatic run_check(input string tag, input bit scramble);
    int t0, wb, db, bb, ec, ef;
    ec = 0;
    ef = 0;
    for (int i = 0; i < 256; i++) begin
      if (b_mem[i] !== 8'(i)) begin
        if (ec == 0) ef = i;
        ec++;
      end
    end
    launch(3, 8'd0, scramble, 256, t0, wb, db, bb);
    chk({tag, "_nwrites"}, 0, wr_cyc.size() - wb, 0);
    chk({tag, "_ndone"}, 0, done_cyc.size() - db, 1);
    if (done_cyc.size() > db) chk({tag, "_done_cycle"}, 0, done_cyc[db], t0 + 258);
    chk({tag, "_busy_cycles"}, 0, busy_cnt - bb, 257);
    chk({tag, "_err"}, 0, o_err, (ec != 0) ? 1 : 0);
    chk({tag, "_err_addr"}, 0, o_err_addr, ef);
    chk({tag, "_err_count"}, 0, o_err_count, ec);
  endtask

  task automatic poke(input int a, input logic [7:0] d);
    step();
    poke_en = 1'b1;
    poke_addr = 8'(a);
    poke_data = d;
    step();
    poke_en = 1'b0;
  endtask

  initial begin
    int t0, wb, db, bb, n, a;
    reset_n = 1'b0;
    repeat (3) step();
    sel = 1'b0;
    check_idle_zero("rst_big");
    sel = 1'b1;
    check_idle_zero("rst_small");
    sel = 1'b0;
    reset_n = 1'b1;
    step();

    run_write("ident", 0, 8'h00, 1'b0);
    run_check("check_clean", 1'b0);
    poke(3, 8'd3 ^ 8'h5A);
    poke(200, 8'd200 ^ 8'h81);
    run_check("check_corrupt", 1'b0);
    run_write("fill_scr", 2, 8'($urandom), 1'b1);
    run_write("ident_scr", 0, 8'($urandom), 1'b1);
    run_check("check_scr", 1'b1);

    for (int k = 0; k < 4; k++) begin
      if (k % 2 == 1) begin
        for (int p = 0; p < 3; p++) begin
          a = int'($urandom_range(0, 255));
          poke(a, 8'(a) ^ 8'($urandom_range(1, 255)));
        end
        run_check("rand_check", 1'b1);
      end else begin
        run_write("rand_write", int'($urandom_range(0, 2)), 8'($urandom), 1'b1);
      end
    end

    sel = 1'b1;
    run_write("small_reverse", 1, 8'h00, 1'b0);
    run_write("small_fill", 2, 8'hA5, 1'b1);
    sel = 1'b0;

    // start held high: one run per IDLE visit, back to back
    step();
    wb = wr_cyc.size();
    db = done_cyc.size();
    bb = busy_cnt;
    start = 1'b1;
    mode_r = 2'd0;
    t0 = cyc;
    repeat (358) step();
    start = 1'b0;
    n = 0;
    while (done_cyc.size() - db < 2 && n < 400) begin
      step();
      n++;
    end
    repeat (3) step();
    chk("hold_nwrites", 0, wr_cyc.size() - wb, 512);
    for (int j = 0; j < 512 && wb + j < wr_cyc.size(); j++) begin
      chk("hold_wcycle", j, wr_cyc[wb+j], t0 + (j / 256) * 258 + 1 + (j % 256));
      chk("hold_wdata", j, wr_dat[wb+j], j % 256);
    end
    chk("hold_ndone", 0, done_cyc.size() - db, 2);
    if (done_cyc.size() - db >= 2) begin
      chk("hold_done0", 0, done_cyc[db], t0 + 257);
      chk("hold_done1", 0, done_cyc[db+1], t0 + 515);
    end
    chk("hold_busy_cycles", 0, busy_cnt - bb, 512);

    // reset asserted while write 100 is on the bus
    step();
    wb = wr_cyc.size();
    db = done_cyc.size();
    start = 1'b1;
    mode_r = 2'd0;
    t0 = cyc;
    step();
    start = 1'b0;
    n = 0;
    while (wr_cyc.size() - wb < 101 && n < 300) begin
      step();
      n++;
    end
    chk("rstmid_reached_i100", 0, cyc, t0 + 101);
    reset_n = 1'b0;
    step();
    check_idle_zero("rstmid");
    reset_n = 1'b1;
    repeat (300) step();
    chk("rstmid_nwrites", 0, wr_cyc.size() - wb, 101);
    chk("rstmid_ndone", 0, done_cyc.size() - db, 0);
    run_write("post_reset", 0, 8'h00, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
